// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state enum and width helper for the LED alarm driver
package led_pkg;

    typedef enum logic [1:0] {
        SHOW      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } led_state_e;

    // Counter width able to hold 0..value-1, never narrower than one bit
    function automatic int clog2_min1(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage

// File: rtl/led_alarm_driver_if.sv
// rtl/led_alarm_driver_if.sv - alarm/count inputs and LED outputs of the LED alarm driver
interface led_alarm_driver_if #(
    parameter int SIZE     = 4,
    parameter int PWM_BITS = 4
);
    logic                alarm;
    logic                ack;
    logic [SIZE-1:0]     count;
    logic [PWM_BITS-1:0] brightness;
    logic [SIZE-1:0]     led;
    logic                busy;

    // Counter side drives the requests and the value to display
    modport master (
        output alarm, ack, count, brightness,
        input  led, busy
    );

    // LED driver side
    modport slave (
        input  alarm, ack, count, brightness,
        output led, busy
    );
endinterface

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - free-running brightness counter and duty comparator
module led_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                en
);
    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] cnt_d;

    // Counter wraps naturally at 2^PWM_BITS
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    // Free-running counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Enable for brightness/2^PWM_BITS of the period; brightness 0 is always dark
    assign en = (cnt_q < brightness);
endmodule

// File: rtl/led_alarm_driver.sv
// rtl/led_alarm_driver.sv - LED bank driver with timed alarm flash; optional dimming via LED_PWM_EN
module led_alarm_driver
    import led_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int BLINK_DIV    = 8,
    parameter int ALARM_BLINKS = 3,
    parameter int PWM_BITS     = 4
) (
    input logic                clk,
    input logic                rst,
    led_alarm_driver_if.slave  bus
);
    localparam int DIV_W = clog2_min1(BLINK_DIV);
    localparam int FL_W  = clog2_min1(ALARM_BLINKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(ALARM_BLINKS);

    led_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [FL_W-1:0]  flash_q, flash_d;
    logic [SIZE-1:0]  led_q, led_d;
    logic             busy_q, busy_d;

    logic             div_term;
    logic [FL_W-1:0]  flash_inc;
    logic             flash_done;
    logic [SIZE-1:0]  led_state;
    logic             pwm_en;

`ifdef LED_PWM_EN
    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .brightness (bus.brightness),
        .en         (pwm_en)
    );
`else
    // Without dimming the LEDs are always enabled and brightness is ignored
    logic unused_brightness;
    assign unused_brightness = ^bus.brightness;
    assign pwm_en = 1'b1;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SHOW;
            div_q   <= '0;
            flash_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            flash_q <= flash_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: ack beats alarm, alarm beats the timed progression
    always_comb begin
        state_d    = state_q;
        div_term   = (div_q == DIV_LAST);
        flash_inc  = flash_q + 1'b1;
        flash_done = (ALARM_BLINKS != 0) && (flash_inc == FL_LAST);
        unique case (state_q)
            SHOW: begin
                if (bus.alarm && !bus.ack) begin
                    state_d = FLASH_ON;
                end
            end
            FLASH_ON: begin
                if (bus.ack) begin
                    state_d = SHOW;
                end else if (bus.alarm) begin
                    state_d = FLASH_ON;
                end else if (div_term) begin
                    state_d = FLASH_OFF;
                end
            end
            FLASH_OFF: begin
                if (bus.ack) begin
                    state_d = SHOW;
                end else if (bus.alarm) begin
                    state_d = FLASH_ON;
                end else if (div_term) begin
                    state_d = flash_done ? SHOW : FLASH_ON;
                end
            end
            default: begin
                state_d = SHOW;
            end
        endcase
    end

    // Counter updates and the LED/busy values registered with the new state
    always_comb begin
        // Divider restarts on every phase change, retrigger or return to SHOW
        if (state_d == SHOW || bus.alarm || state_d != state_q) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        // Flash counter only advances at the end of an off phase
        if (state_d == SHOW || bus.alarm || ALARM_BLINKS == 0) begin
            flash_d = '0;
        end else if (state_q == FLASH_OFF && div_term) begin
            flash_d = flash_inc;
        end else begin
            flash_d = flash_q;
        end

        unique case (state_d)
            FLASH_ON:  led_state = '1;
            FLASH_OFF: led_state = '0;
            default:   led_state = bus.count;
        endcase

        led_d  = led_state & {SIZE{pwm_en}};
        busy_d = (state_d != SHOW);
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
endmodule
